ram_access_arbiter: RTL and testbench

- Shares the single 10-bit command port of the on-chip 8x-addressed RAM between two requesters: req0 (SPI-side) and req1 (local host/BIST).
- Accepts one whole read or write transaction per grant and expands it into the RAM's command sequence.
- Waits for the RAM's read response, then returns the read data to the granted requester.
- Sits between the requesters and the RAM; it is the only driver of the RAM command port.

---
 rtl/ram_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Two-requester arbiter for the shared RAM command port: grants one whole
// read/write transaction at a time and expands it into RAM command words.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req0_we,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                req0_ready,
    output logic                req0_rvalid,
    output logic [DATA_W-1:0]   req0_rdata,
    output logic                req0_err,
    input  logic                req1_valid,
    input  logic                req1_we,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                req1_ready,
    output logic                req1_rvalid,
    output logic [DATA_W-1:0]   req1_rdata,
    output logic                req1_err,
    output logic [DATA_W+1:0]   ram_din,
    output logic                ram_rx_valid,
    input  logic [DATA_W-1:0]   ram_dout,
    input  logic                ram_tx_valid
);

    localparam int unsigned CMD_W = 2;
    localparam int unsigned DIN_W = CMD_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CMD_W-1:0] CMD_WADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WDATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_READ  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, GAP, RCMD, WAIT, RESP
    } state_t;

    state_t              state, state_nx;
    logic                grant0_c, grant1_c, accept_c;
    logic                resp_c, resp_err_c;
    logic [DIN_W-1:0]    din_nx;
    logic                rx_nx;
    logic                last_grant;
    logic                lat_we;
    logic                lat_id;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [CNT_W-1:0]    cnt;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;
    assign sel_we     = grant1_c ? req1_we    : req0_we;
    assign sel_addr   = grant1_c ? req1_addr  : req0_addr;
    assign sel_wdata  = grant1_c ? req1_wdata : req0_wdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Grant, next state and next values of the registered RAM/response outputs
    always_comb begin
        state_nx   = state;
        grant0_c   = 1'b0;
        grant1_c   = 1'b0;
        accept_c   = 1'b0;
        resp_c     = 1'b0;
        resp_err_c = 1'b0;
        din_nx     = '0;
        rx_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) grant0_c = 1'b1;
                else if (req1_valid)                           grant1_c = 1'b1;
                if (grant0_c || grant1_c) begin
                    accept_c = 1'b1;
                    state_nx = ADDR;
                    rx_nx    = 1'b1;
                    din_nx   = {sel_we ? CMD_WADDR : CMD_RADDR, DATA_W'(sel_addr)};
                end
            end
            ADDR: begin
                rx_nx = 1'b1;
                if (lat_we) begin
                    state_nx = DATA;
                    din_nx   = {CMD_WDATA, lat_wdata};
                end else begin
                    state_nx = RCMD;
                    din_nx   = {CMD_READ, DATA_W'(0)};
                end
            end
            DATA:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            RCMD:    state_nx = WAIT;
            WAIT: begin
                if (ram_tx_valid) begin
                    resp_c   = 1'b1;
                    state_nx = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_c     = 1'b1;
                    resp_err_c = 1'b1;
                    state_nx   = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Transaction latch, fairness pointer and WAIT timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
        end else begin
            if (accept_c) begin
                last_grant <= grant1_c;
                lat_id     <= grant1_c;
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
            end
            if (state == WAIT) cnt <= cnt + CNT_W'(1);
            else               cnt <= '0;
        end
    end

    // Registered RAM command port and per-requester read responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            req0_rvalid  <= 1'b0;
            req0_rdata   <= '0;
            req0_err     <= 1'b0;
            req1_rvalid  <= 1'b0;
            req1_rdata   <= '0;
            req1_err     <= 1'b0;
        end else begin
            ram_din      <= din_nx;
            ram_rx_valid <= rx_nx;
            req0_rvalid  <= resp_c && !lat_id;
            req1_rvalid  <= resp_c && lat_id;
            if (resp_c && !lat_id) begin
                req0_rdata <= resp_err_c ? '0 : ram_dout;
                req0_err   <= resp_err_c;
            end
            if (resp_c && lat_id) begin
                req1_rdata <= resp_err_c ? '0 : ram_dout;
                req1_err   <= resp_err_c;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a small behavioural RAM.
module tb_ram_access_arbiter;

    logic       clk, rst_n;
    logic       req0_valid, req0_we, req0_ready, req0_rvalid, req0_err;
    logic [7:0] req0_addr, req0_wdata, req0_rdata;
    logic       req1_valid, req1_we, req1_ready, req1_rvalid, req1_err;
    logic [7:0] req1_addr, req1_wdata, req1_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] waddr, raddr;
    logic       pend;
    logic       mute;
    logic       stale_en;

    ram_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: read data appears 2 cycles after the read strobe; stale_en forces a bogus tx_valid
    always @(posedge clk) begin
        pend         <= ram_rx_valid && (ram_din[9:8] == 2'b11) && !mute;
        ram_tx_valid <= pend || stale_en;
        ram_dout     <= pend ? mem[raddr] : 8'hEE;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: waddr <= ram_din[7:0];
                2'b01: mem[waddr] <= ram_din[7:0];
                2'b10: raddr <= ram_din[7:0];
                default: ;
            endcase
        end
    end

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ram_din, ram_rx_valid, req0_ready, req1_ready, req0_rvalid, req1_rvalid,
             req0_rdata, req1_rdata, req0_err, req1_err} !== 33'd0) begin
            bad++;
            $display("FAIL reset_outputs got din=%h rx=%b rdy=%b%b rv=%b%b rd=%h/%h err=%b%b want all 0",
                     ram_din, ram_rx_valid, req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                     req0_rdata, req1_rdata, req0_err, req1_err);
        end
    endtask

    task automatic test_write(input int id, input logic [7:0] a, input logic [7:0] d);
        logic rdy;
        drive(id, 1'b1, 1'b1, a, d); #1;
        rdy = (id == 0) ? req0_ready : req1_ready;
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL wr_accept id=%0d got=%b want=1", id, rdy); end
        @(posedge clk); @(negedge clk);
        drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
        total++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 2'b00, a}) begin
            bad++; $display("FAIL wr_addr_cmd got rx=%b din=%h want rx=1 din=%h", ram_rx_valid, ram_din, {2'b00, a});
        end
        @(negedge clk);
        total++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 2'b01, d}) begin
            bad++; $display("FAIL wr_data_cmd got rx=%b din=%h want rx=1 din=%h", ram_rx_valid, ram_din, {2'b01, d});
        end
        @(negedge clk);
        drive(id, 1'b1, 1'b1, a, d); #1;
        rdy = (id == 0) ? req0_ready : req1_ready;
        total++;
        if ({rdy, ram_rx_valid, ram_din} !== 12'd0) begin
            bad++; $display("FAIL wr_gap got ready=%b rx=%b din=%h want 0/0/000", rdy, ram_rx_valid, ram_din);
        end
        @(negedge clk); #1;
        rdy = (id == 0) ? req0_ready : req1_ready;
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL wr_ready_after_4 got=%b want=1", rdy); end
        drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
    endtask

    task automatic test_read(input int id, input logic [7:0] a, input logic [7:0] exp_d,
                             input logic exp_err, input int exp_lat, input logic clr_stale);
        int   cyc;
        logic got, rdy, rv, rv_other, er;
        logic [7:0] rd;
        drive(id, 1'b1, 1'b0, a, 8'h00); #1;
        rdy = (id == 0) ? req0_ready : req1_ready;
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL rd_accept id=%0d got=%b want=1", id, rdy); end
        @(posedge clk); @(negedge clk);
        drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
        total++;
        if ({ram_rx_valid, ram_din} !== {1'b1, 2'b10, a}) begin
            bad++; $display("FAIL rd_addr_cmd got rx=%b din=%h want rx=1 din=%h", ram_rx_valid, ram_din, {2'b10, a});
        end
        cyc = 1; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                if (clr_stale) stale_en = 1'b0;
                total++;
                if ({ram_rx_valid, ram_din} !== 11'h700) begin
                    bad++; $display("FAIL rd_read_cmd got rx=%b din=%h want rx=1 din=300", ram_rx_valid, ram_din);
                end
            end
            got = (id == 0) ? req0_rvalid : req1_rvalid;
        end
        rd       = (id == 0) ? req0_rdata : req1_rdata;
        er       = (id == 0) ? req0_err : req1_err;
        rv_other = (id == 0) ? req1_rvalid : req0_rvalid;
        total++;
        if (cyc != exp_lat) begin bad++; $display("FAIL rd_latency id=%0d got=%0d want=%0d", id, cyc, exp_lat); end
        total++;
        if ({rd, er, rv_other} !== {exp_d, exp_err, 1'b0}) begin
            bad++; $display("FAIL rd_response id=%0d got rdata=%h err=%b other_rv=%b want rdata=%h err=%b other_rv=0",
                            id, rd, er, rv_other, exp_d, exp_err);
        end
        @(negedge clk);
        rv = (id == 0) ? req0_rvalid : req1_rvalid;
        rd = (id == 0) ? req0_rdata : req1_rdata;
        total++;
        if ({rv, rd} !== {1'b0, exp_d}) begin
            bad++; $display("FAIL rd_pulse_hold got rvalid=%b rdata=%h want rvalid=0 rdata=%h", rv, rd, exp_d);
        end
    endtask

    task automatic test_timeout();
        mute = 1'b1;
        test_read(1, 8'h05, 8'h00, 1'b1, 18, 1'b0);
        mute = 1'b0;
        test_read(1, 8'h05, 8'hA5, 1'b0, 5, 1'b0);
    endtask

    task automatic test_stale();
        test_write(1, 8'h3C, 8'h5A);
        stale_en = 1'b1;
        @(negedge clk);
        test_read(0, 8'h3C, 8'h5A, 1'b0, 5, 1'b1);
    endtask

    task automatic test_back_to_back();
        int seq[$];
        int cyc;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h3C, 8'h00);
        cyc = 0;
        while (seq.size() < 4 && cyc < 60) begin
            #1;
            total++;
            if (req0_ready && req1_ready) begin bad++; $display("FAIL arb_one_hot got ready0=1 ready1=1 want at most one"); end
            if (req0_ready) seq.push_back(0);
            if (req1_ready) seq.push_back(1);
            @(negedge clk);
            cyc++;
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        total++;
        if (seq.size() != 4) begin
            bad++; $display("FAIL arb_grant_count got=%0d want=4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (seq[i] != (i % 2)) begin bad++; $display("FAIL arb_order idx=%0d got=%0d want=%0d", i, seq[i], i % 2); end
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        mute = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
        @(posedge clk); @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ram_din, ram_rx_valid, req0_rvalid, req0_rdata, req0_err, req1_rvalid} !== 22'd0) begin
            bad++; $display("FAIL rst_mid_wait got din=%h rx=%b rv0=%b rd0=%h err0=%b rv1=%b want all 0",
                            ram_din, ram_rx_valid, req0_rvalid, req0_rdata, req0_err, req1_rvalid);
        end
        mute = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (req0_rvalid !== 1'b0) begin bad++; $display("FAIL rst_no_rvalid got=%b want=0", req0_rvalid); end
        rst_n = 1'b1;
        test_read(1, 8'h3C, 8'h5A, 1'b0, 5, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; mute = 1'b0; stale_en = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        apply_reset();
        test_write(0, 8'h05, 8'hA5);
        test_read(0, 8'h05, 8'hA5, 1'b0, 5, 1'b0);
        test_timeout();
        test_stale();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
